// File: rtl/gpio_pio_pkg.sv
// Shared constants for the debounced GPIO PIO: register word offsets and channel limits.
// The debounce stage itself is selected by GPIO_DEBOUNCE_EN inside gpio_debounce_ch.
package gpio_pio_pkg;

   localparam int unsigned MAX_CH = 32;

   localparam logic [2:0] OFS_DATA_IN  = 3'd0;
   localparam logic [2:0] OFS_DATA_OUT = 3'd1;
   localparam logic [2:0] OFS_OUT_SET  = 3'd2;
   localparam logic [2:0] OFS_OUT_CLR  = 3'd3;
   localparam logic [2:0] OFS_IRQ_MASK = 3'd4;
   localparam logic [2:0] OFS_EDGE_SEL = 3'd5;
   localparam logic [2:0] OFS_EDGE_CAP = 3'd6;
   localparam logic [2:0] OFS_RSVD     = 3'd7;

   typedef enum logic [2:0] {
      REG_DATA_IN  = OFS_DATA_IN,
      REG_DATA_OUT = OFS_DATA_OUT,
      REG_OUT_SET  = OFS_OUT_SET,
      REG_OUT_CLR  = OFS_OUT_CLR,
      REG_IRQ_MASK = OFS_IRQ_MASK,
      REG_EDGE_SEL = OFS_EDGE_SEL,
      REG_EDGE_CAP = OFS_EDGE_CAP,
      REG_RSVD     = OFS_RSVD
   } reg_addr_e;

endpackage

// File: rtl/gpio_debounce_ch.sv
// One input channel: 2-flop synchronizer followed by a stable-count debouncer.
// GPIO_DEBOUNCE_EN defined: counter stage present; undefined: output is the synchronizer output.
module gpio_debounce_ch
   import gpio_pio_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin_in,
   output logic deb_out
);

   logic [1:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[0], pin_in};
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          deb_q, deb_d;

   // Count consecutive cycles of disagreement; any agreeing cycle restarts the count.
   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync_q[1] != deb_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            deb_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         deb_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         deb_q  <= deb_d;
      end
   end

   assign deb_out = deb_q;
`else
   // DEB_CYCLES has no effect without the debounce stage.
   logic deb_cycles_unused;
   assign deb_cycles_unused = ^DEB_CYCLES;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign deb_out = sync_q[1];
`endif

endmodule

// File: rtl/gpio_debounce_pio.sv
// Avalon-MM GPIO block with debounced inputs, set/clear outputs and edge-capture interrupt.
// Debounce counters are present only when GPIO_DEBOUNCE_EN is defined.
module gpio_debounce_pio
   import gpio_pio_pkg::*;
#(
   parameter int unsigned      N_IN        = 14,
   parameter int unsigned      N_OUT       = 10,
   parameter int unsigned      DEB_CYCLES  = 50000,
   parameter logic [N_OUT-1:0] OUT_RST_VAL = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [N_IN-1:0]   gpio_in,
   output logic [N_OUT-1:0]  gpio_out,
   output logic              irq
);

   logic [N_IN-1:0]  deb;
   logic [N_IN-1:0]  deb_prev_q, deb_prev_d;
   logic [N_OUT-1:0] dout_q, dout_d;
   logic [N_IN-1:0]  mask_q, mask_d;
   logic [N_IN-1:0]  sel_q, sel_d;
   logic [N_IN-1:0]  cap_q, cap_d;
   logic             irq_q, irq_d;
   logic [31:0]      rdata_q, rdata_d;

   logic [N_IN-1:0]  edge_hit;
   logic [N_IN-1:0]  w1c;
   logic [N_IN-1:0]  wd_in;
   logic [N_OUT-1:0] wd_out;
   logic [31:0]      rd_mux;
   logic             writedata_unused;

   for (genvar i = 0; i < N_IN; i++) begin : g_ch
      gpio_debounce_ch #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_ch (
         .clk     (clk),
         .reset_n (reset_n),
         .pin_in  (gpio_in[i]),
         .deb_out (deb[i])
      );
   end

   assign wd_in            = writedata[N_IN-1:0];
   assign wd_out           = writedata[N_OUT-1:0];
   assign writedata_unused = ^writedata;

   always_comb begin
      rd_mux = '0;
      case (reg_addr_e'(address))
         REG_DATA_IN:  rd_mux = 32'(deb);
         REG_DATA_OUT: rd_mux = 32'(dout_q);
         REG_IRQ_MASK: rd_mux = 32'(mask_q);
         REG_EDGE_SEL: rd_mux = 32'(sel_q);
         REG_EDGE_CAP: rd_mux = 32'(cap_q);
         default:      rd_mux = '0;
      endcase
   end

   // deb_prev_q starts at the reset value of deb, so reset itself never looks like an edge.
   always_comb begin
      dout_d     = dout_q;
      mask_d     = mask_q;
      sel_d      = sel_q;
      w1c        = '0;
      deb_prev_d = deb;
      edge_hit   = (sel_q & deb & ~deb_prev_q) | (~sel_q & ~deb & deb_prev_q);

      if (write) begin
         case (reg_addr_e'(address))
            REG_DATA_OUT: dout_d = wd_out;
            REG_OUT_SET:  dout_d = dout_q | wd_out;
            REG_OUT_CLR:  dout_d = dout_q & ~wd_out;
            REG_IRQ_MASK: mask_d = wd_in;
            REG_EDGE_SEL: sel_d  = wd_in;
            REG_EDGE_CAP: w1c    = wd_in;
            default:      ;
         endcase
      end

      cap_d   = (cap_q & ~w1c) | edge_hit;
      irq_d   = |(cap_q & mask_q);
      rdata_d = read ? rd_mux : rdata_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_prev_q <= '0;
         dout_q     <= OUT_RST_VAL;
         mask_q     <= '0;
         sel_q      <= '0;
         cap_q      <= '0;
         irq_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         deb_prev_q <= deb_prev_d;
         dout_q     <= dout_d;
         mask_q     <= mask_d;
         sel_q      <= sel_d;
         cap_q      <= cap_d;
         irq_q      <= irq_d;
         rdata_q    <= rdata_d;
      end
   end

   assign gpio_out = dout_q;
   assign irq      = irq_q;
   assign readdata = rdata_q;

endmodule

// File: tb/tb_gpio_debounce_pio.sv
// Bench for gpio_debounce_pio: directed scenarios plus random traffic against a reference model.
// Expected debounce latency follows GPIO_DEBOUNCE_EN.
module tb_gpio_debounce_pio;

   localparam int               N_IN    = 14;
   localparam int               N_OUT   = 10;
   localparam int               DEB     = 4;
   localparam logic [N_OUT-1:0] OUT_RST = 10'h2A;
`ifdef GPIO_DEBOUNCE_EN
   localparam int               LAT     = DEB + 2;
`else
   localparam int               LAT     = 2;
`endif

   logic             clk;
   logic             reset_n;
   logic [2:0]       address;
   logic             read;
   logic             write;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [N_IN-1:0]  gpio_in;
   logic [N_OUT-1:0] gpio_out;
   logic             irq;

   int n_checks = 0;
   int n_errors = 0;

   gpio_debounce_pio #(
      .N_IN        (N_IN),
      .N_OUT       (N_OUT),
      .DEB_CYCLES  (DEB),
      .OUT_RST_VAL (OUT_RST)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .read      (read),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pin history sampled at each rising edge, newest first.
   logic [N_IN-1:0]  pin_hist [$];
   logic [N_IN-1:0]  m_deb, m_deb_prev, m_mask, m_sel, m_cap;
   logic [N_OUT-1:0] m_dout;
   logic             m_irq;
   logic [31:0]      m_rdata;

   function automatic logic [31:0] m_reg(input logic [2:0] a);
      case (a)
         3'd0:    return 32'(m_deb);
         3'd1:    return 32'(m_dout);
         3'd4:    return 32'(m_mask);
         3'd5:    return 32'(m_sel);
         3'd6:    return 32'(m_cap);
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      pin_hist.delete();
      repeat (DEB + 2) pin_hist.push_front('0);
      m_deb      = '0;
      m_deb_prev = '0;
      m_mask     = '0;
      m_sel      = '0;
      m_cap      = '0;
      m_dout     = OUT_RST;
      m_irq      = 1'b0;
      m_rdata    = '0;
   endtask

   task automatic model_step();
      logic [31:0]      rv;
      logic [N_IN-1:0]  deb_new, hit, w1c;
      logic             all_other;
      rv = m_reg(address);
      pin_hist.push_front(gpio_in);
      if (pin_hist.size() > DEB + 2) void'(pin_hist.pop_back());
`ifdef GPIO_DEBOUNCE_EN
      // A channel flips once the synchronized pin has shown the opposite level for DEB cycles.
      deb_new = m_deb;
      for (int i = 0; i < N_IN; i++) begin
         all_other = 1'b1;
         for (int k = 0; k < DEB; k++)
            if (pin_hist[k + 2][i] == m_deb[i]) all_other = 1'b0;
         if (all_other) deb_new[i] = ~m_deb[i];
      end
`else
      all_other = 1'b0;
      deb_new   = pin_hist[1];
`endif
      hit = (m_sel & m_deb & ~m_deb_prev) | (~m_sel & ~m_deb & m_deb_prev);
      w1c = '0;
      m_irq = |(m_cap & m_mask);
      if (read) m_rdata = rv;
      if (write) begin
         case (address)
            3'd1: m_dout = writedata[N_OUT-1:0];
            3'd2: m_dout = m_dout | writedata[N_OUT-1:0];
            3'd3: m_dout = m_dout & ~writedata[N_OUT-1:0];
            3'd4: m_mask = writedata[N_IN-1:0];
            3'd5: m_sel  = writedata[N_IN-1:0];
            3'd6: w1c    = writedata[N_IN-1:0];
            default: ;
         endcase
      end
      m_cap      = (m_cap & ~w1c) | hit;
      m_deb_prev = m_deb;
      m_deb      = deb_new;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("gpio_out", 32'(gpio_out), 32'(m_dout));
      check("irq", 32'(irq), 32'(m_irq));
      check("readdata", readdata, m_rdata);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write     = 1'b1;
      tick();
      write     = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] rv);
      address = a;
      read    = 1'b1;
      tick();
      read    = 1'b0;
      rv      = readdata;
   endtask

   initial begin
      logic [31:0]     rv;
      logic [N_IN-1:0] hold;
      int              lat;
      int              op;
      logic            seen_low;

      reset_n   = 1'b0;
      address   = '0;
      read      = 1'b0;
      write     = 1'b0;
      writedata = '0;
      gpio_in   = '0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check("rst_gpio_out", 32'(gpio_out), 32'h2A);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_readdata", readdata, 32'h0);
      reset_n = 1'b1;

      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a), rv);
         check("reset_reg", rv, (a == 1) ? 32'h2A : 32'h0);
      end

      // Clean rise on pin 0 with DATA_IN polled every cycle
      address    = 3'd0;
      read       = 1'b1;
      gpio_in[0] = 1'b1;
      lat        = 0;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         tick();
         if (readdata[0]) lat = n;
      end
      check("deb_latency", 32'(lat), 32'(LAT + 1));

      gpio_in[0] = 1'b0;
      repeat (3) tick();
      gpio_in[0] = 1'b1;
      seen_low   = 1'b0;
      repeat (10) begin
         tick();
         if (!readdata[0]) seen_low = 1'b1;
      end
`ifdef GPIO_DEBOUNCE_EN
      check("glitch_filtered", 32'(seen_low), 32'h0);
`endif
      read = 1'b0;

      bus_write(3'd1, 32'h0F0);
      check("data_out", 32'(gpio_out), 32'h0F0);
      bus_write(3'd2, 32'h001);
      check("out_set", 32'(gpio_out), 32'h0F1);
      bus_write(3'd3, 32'h010);
      check("out_clr", 32'(gpio_out), 32'h0E1);
      bus_read(3'd2, rv);
      check("out_set_reads0", rv, 32'h0);
      bus_read(3'd7, rv);
      check("rsvd_reads0", rv, 32'h0);

      // Rising-edge capture and interrupt on bit 0
      bus_write(3'd6, 32'hFFFF_FFFF);
      bus_write(3'd4, 32'h1);
      bus_write(3'd5, 32'h1);
      gpio_in[0] = 1'b0;
      repeat (LAT + 2) tick();
      gpio_in[0] = 1'b1;
      repeat (LAT + 3) tick();
      bus_read(3'd6, rv);
      check("edge_cap_rise", rv, 32'h1);
      check("irq_set", 32'(irq), 32'h1);
      bus_write(3'd6, 32'h1);
      check("irq_hold_after_w1c", 32'(irq), 32'h1);
      tick();
      check("irq_clear", 32'(irq), 32'h0);

      // W1C landing on the same cycle as a new edge
      bus_write(3'd5, 32'h0);
      gpio_in[0] = 1'b0;
      repeat (LAT + 3) tick();
      check("irq_fall", 32'(irq), 32'h1);
      bus_write(3'd5, 32'h1);
      gpio_in[0] = 1'b1;
      repeat (LAT) tick();
      bus_write(3'd6, 32'h1);
      check("irq_stays", 32'(irq), 32'h1);
      bus_read(3'd6, rv);
      check("edge_cap_stays", rv, 32'h1);
      check("irq_stays_later", 32'(irq), 32'h1);

      repeat (400) begin
         if ($urandom_range(0, 5) == 0) gpio_in[$urandom_range(0, N_IN - 1)] ^= 1'b1;
         op        = int'($urandom_range(0, 3));
         address   = 3'($urandom_range(0, 7));
         writedata = $urandom();
         read      = (op & 1) != 0;
         write     = (op & 2) != 0;
         tick();
         read      = 1'b0;
         write     = 1'b0;
      end

      // Reset in the middle of a debounce window
      gpio_in = N_IN'($urandom());
      repeat (2) tick();
      #3;
      reset_n = 1'b0;
      #1;
      check("midrst_gpio_out", 32'(gpio_out), 32'h2A);
      check("midrst_irq", 32'(irq), 32'h0);
      check("midrst_readdata", readdata, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      hold    = gpio_in;
      address = 3'd0;
      read    = 1'b1;
      repeat (LAT + 2) tick();
      check("post_reset_deb", readdata, 32'(hold));
      read = 1'b0;
      bus_read(3'd6, rv);
      check("no_reset_edge", rv, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
